msrv32_rf_wb_scheduler: RTL and testbench
=========================================

// Module: msrv32_rf_wb_scheduler
// PURPOSE
//  Schedules the single write port of the integer register file between two writeback
//  requesters: req0 (ALU/CSR) and req1 (load unit). Arbitration is round-robin.
//  Tracks pending destination registers in a busy scoreboard, so decode can stall on
//  RAW and WAW hazards. Sits between the execute/load stages and the integer register
//  file; drives its wr_en_in, rd_addr_in and rd_in.
// PARAMETERS
//  WIDTH       32  data width of a register
//  HEIGHT      32  number of architectural registers (x0..x31)
//  ADDR_WIDTH  5   register address width
// PORTS
//  msrv32_mp_clk_in   in   1           clock; all state updates on the rising edge
//  msrv32_mp_rst_in   in   1           synchronous reset, active-high
//  req0_valid_in      in   1           ALU/CSR writeback request
//  req0_addr_in       in   ADDR_WIDTH  ALU/CSR destination register
//  req0_data_in       in   WIDTH       ALU/CSR result
//  req0_ready_out     out  1           req0 accepted this cycle (combinational)
//  req1_valid_in      in   1           load writeback request
//  req1_addr_in       in   ADDR_WIDTH  load destination register
//  req1_data_in       in   WIDTH       load data
//  req1_ready_out     out  1           req1 accepted this cycle (combinational)
//  issue_en_in        in   1           decode issues an instruction that writes a register
//  issue_rd_in        in   ADDR_WIDTH  destination of the issued instruction
//  rs_1_addr_in       in   ADDR_WIDTH  source 1 of the instruction in decode
//  rs_2_addr_in       in   ADDR_WIDTH  source 2 of the instruction in decode
//  hazard_out         out  1           decode must stall (combinational)
//  wr_en_out          out  1           register-file write enable (registered)
//  rd_addr_out        out  ADDR_WIDTH  register-file write address (registered)
//  rd_out             out  WIDTH       register-file write data (registered)
// BEHAVIOUR
//  - Reset: wr_en_out=0, rd_addr_out=0, rd_out=0, all busy bits cleared, last_grant=1.
//    The first contended grant therefore goes to req0. Reset mid-operation drops any
//    accepted-but-unwritten request; no write is issued in the cycle after reset.
//  - Arbitration, combinational within the cycle:
//    * Only one requester valid: that requester is granted.
//    * Both valid: the requester not equal to last_grant is granted.
//    * last_grant updates only when a grant occurs.
//  - reqN_ready_out = grant to N. At most one ready per cycle; ready is never asserted
//    without the matching valid. Ready is 0 while msrv32_mp_rst_in=1.
//  - Accept in cycle N leads to a write in cycle N+1 (latency 1):
//    * wr_en_out=1, with rd_addr_out/rd_out holding the granted addr/data.
//    * Throughput is one write per cycle, with no bubbles under back-to-back requests.
//    * With no grant, wr_en_out=0; rd_addr_out and rd_out hold their previous values.
//  - A granted request with addr=0 is consumed, but wr_en_out stays 0 (x0 never written).
//  - Scoreboard busy[HEIGHT-1:1] (bit 0 is constant 0):
//    * Set: issue_en_in && issue_rd_in!=0 sets busy[issue_rd_in] at the clock edge.
//    * Clear: a grant with addr!=0 clears busy[addr] at the same edge as acceptance.
//    * Set and clear of the same register in one cycle: set wins (newer producer).
//    * A grant to a non-busy register is legal and leaves busy unchanged.
//  - hazard_out = busy[rs_1_addr_in] | busy[rs_2_addr_in] | (issue_en_in & busy[issue_rd_in]).
//    * Uses pre-edge busy values, so the first term is RAW and the WAW term stalls issue
//      onto a pending destination.
//    * Writeback in cycle N does not bypass hazard_out; the consumer sees the hazard
//      released in cycle N+1.
//  - Address 0 never causes a hazard.
// TESTING
//  1 Reset: assert rst 2 cycles with req0/req1 valid -> readys=0, wr_en_out=0, hazard_out=0.
//  2 Single: req0 valid addr=5 data=0xDEADBEEF, cycle N -> ready0=1 at N; at N+1
//    wr_en_out=1, rd_addr_out=5, rd_out=0xDEADBEEF.
//  3 Contention: both valid for 4 cycles (addr 3/4), first contended cycle after reset
//    -> grants req0,req1,req0,req1; wr_en_out=1 for 4 consecutive cycles.
//  4 Scoreboard: issue rd=7; next cycle rs_1=7 -> hazard_out=1; req1 writes x7 at
//    cycle M -> hazard_out=0 from M+1. Same-cycle issue rd=7 and grant addr=7
//    -> busy[7] stays 1.
//  5 x0: issue rd=0, then req0 addr=0 data=0x1 -> ready0=1, wr_en_out=0, hazard_out
//    never set for rs=0.
//  6 WAW/reset: busy[9] set, issue_en with rd=9 -> hazard_out=1; assert rst -> busy
//    cleared, hazard_out=0 in the cycle after.

Source files
------------

// File: rtl/msrv32_rf_wb_scheduler.sv
// Register-file write-port scheduler: round-robin arbitration between the ALU/CSR and
// load writeback paths, plus a busy scoreboard that drives the decode hazard stall.
module msrv32_rf_wb_scheduler #(
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  msrv32_mp_clk_in,
  input  logic                  msrv32_mp_rst_in,
  input  logic                  req0_valid_in,
  input  logic [ADDR_WIDTH-1:0] req0_addr_in,
  input  logic [WIDTH-1:0]      req0_data_in,
  output logic                  req0_ready_out,
  input  logic                  req1_valid_in,
  input  logic [ADDR_WIDTH-1:0] req1_addr_in,
  input  logic [WIDTH-1:0]      req1_data_in,
  output logic                  req1_ready_out,
  input  logic                  issue_en_in,
  input  logic [ADDR_WIDTH-1:0] issue_rd_in,
  input  logic [ADDR_WIDTH-1:0] rs_1_addr_in,
  input  logic [ADDR_WIDTH-1:0] rs_2_addr_in,
  output logic                  hazard_out,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] rd_addr_out,
  output logic [WIDTH-1:0]      rd_out
);

  // last_grant_q: 1 means req1 won the most recent grant
  logic                  last_grant_q, last_grant_d;
  logic [HEIGHT-1:0]     busy_q, busy_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [WIDTH-1:0]      rd_q, rd_d;

  logic                  grant0, grant1, grant_any;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [WIDTH-1:0]      g_data;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!msrv32_mp_rst_in) begin
      if (req0_valid_in && (!req1_valid_in || last_grant_q)) grant0 = 1'b1;
      else if (req1_valid_in)                                grant1 = 1'b1;
    end
    grant_any = grant0 | grant1;
    g_addr    = grant1 ? req1_addr_in : req0_addr_in;
    g_data    = grant1 ? req1_data_in : req0_data_in;
  end

  always_comb begin
    last_grant_d = grant_any ? grant1 : last_grant_q;
    wr_en_d      = grant_any && (g_addr != '0);
    rd_addr_d    = wr_en_d ? g_addr : rd_addr_q;
    rd_d         = wr_en_d ? g_data : rd_q;
    busy_d       = busy_q;
    if (wr_en_d) busy_d[g_addr] = 1'b0;
    // A new producer issued in the same cycle outranks the retiring one
    if (issue_en_in && (issue_rd_in != '0)) busy_d[issue_rd_in] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge msrv32_mp_clk_in) begin
    if (msrv32_mp_rst_in) begin
      last_grant_q <= 1'b1;
      busy_q       <= '0;
      wr_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rd_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      wr_en_q      <= wr_en_d;
      rd_addr_q    <= rd_addr_d;
      rd_q         <= rd_d;
    end
  end

  assign req0_ready_out = grant0;
  assign req1_ready_out = grant1;
  assign hazard_out     = busy_q[rs_1_addr_in] | busy_q[rs_2_addr_in] |
                          (issue_en_in & busy_q[issue_rd_in]);
  assign wr_en_out      = wr_en_q;
  assign rd_addr_out    = rd_addr_q;
  assign rd_out         = rd_q;

endmodule

// File: tb/tb_msrv32_rf_wb_scheduler.sv
// Bench for msrv32_rf_wb_scheduler: directed scenarios plus a randomized run against a
// transaction-level model of the arbiter, write port and scoreboard.
module tb_msrv32_rf_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_v, r1_v, r0_rdy, r1_rdy;
  logic [4:0]  r0_a, r1_a, iss_rd, rs1, rs2, wr_addr;
  logic [31:0] r0_d, r1_d, wr_data;
  logic        iss_en, hazard, wr_en;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_last = 1;
  bit [31:0]   m_busy = '0;
  bit          m_wr   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  always #5 clk = ~clk;

  msrv32_rf_wb_scheduler dut (
    .msrv32_mp_clk_in(clk), .msrv32_mp_rst_in(rst),
    .req0_valid_in(r0_v), .req0_addr_in(r0_a), .req0_data_in(r0_d), .req0_ready_out(r0_rdy),
    .req1_valid_in(r1_v), .req1_addr_in(r1_a), .req1_data_in(r1_d), .req1_ready_out(r1_rdy),
    .issue_en_in(iss_en), .issue_rd_in(iss_rd), .rs_1_addr_in(rs1), .rs_2_addr_in(rs2),
    .hazard_out(hazard), .wr_en_out(wr_en), .rd_addr_out(wr_addr), .rd_out(wr_data)
  );

  function automatic int model_winner();  // -1 none, else requester index
    if (rst) return -1;
    if (r0_v && r1_v) return 1 - m_last;
    if (r0_v) return 0;
    if (r1_v) return 1;
    return -1;
  endfunction

  function automatic bit model_hazard();
    return m_busy[rs1] | m_busy[rs2] | (iss_en & m_busy[iss_rd]);
  endfunction

  task automatic idle();
    r0_v = 0; r1_v = 0; iss_en = 0; rs1 = 0; rs2 = 0; iss_rd = 0;
    r0_a = 0; r1_a = 0; r0_d = 0; r1_d = 0;
  endtask

  // Advance one clock, applying the transaction the current inputs describe to the model
  task automatic tick();
    int w;
    logic [4:0]  a;
    logic [31:0] d;
    w = model_winner();
    @(posedge clk);
    if (rst) begin
      m_last = 1; m_busy = '0; m_wr = 0; m_addr = '0; m_data = '0;
    end else begin
      m_wr = 0;
      if (w >= 0) begin
        a = (w == 1) ? r1_a : r0_a;
        d = (w == 1) ? r1_d : r0_d;
        m_last = w;
        if (a != 0) begin
          m_busy[a] = 0; m_wr = 1; m_addr = a; m_data = d;
        end
      end
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; r0_v = 1; r1_v = 1; r0_a = 2; r1_a = 6;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin
        n_bad++; $display("FAIL reset_ready: got %b%b want 00", r0_rdy, r1_rdy);
      end
      tick();
    end
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 || hazard !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h hazard=%b want 0/0/0/0",
               wr_en, wr_addr, wr_data, hazard);
    end
    rst = 0; idle();
  endtask

  task automatic test_single();
    idle(); r0_v = 1; r0_a = 5; r0_d = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin
      n_bad++; $display("FAIL single_ready: got %b%b want 10", r0_rdy, r1_rdy);
    end
    tick(); idle();
    n_cmp++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_write: got %b/%0d/%h want 1/5/deadbeef", wr_en, wr_addr, wr_data);
    end
    tick();
    n_cmp++;
    if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_hold: got %b/%0d/%h want 0/5/deadbeef", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    idle(); rst = 1; tick(); rst = 0;
    for (int i = 0; i < 4; i++) begin
      d0 = $urandom; d1 = $urandom;
      r0_v = 1; r1_v = 1; r0_a = 3; r1_a = 4; r0_d = d0; r1_d = d1;
      #1;
      n_cmp++;
      if (r0_rdy !== ((i % 2) == 0) || r1_rdy !== ((i % 2) == 1)) begin
        n_bad++; $display("FAIL contention_grant[%0d]: got %b%b want %b%b", i, r0_rdy, r1_rdy,
                          (i % 2) == 0, (i % 2) == 1);
      end
      tick();
      n_cmp++;
      if (wr_en !== 1'b1 || wr_addr !== ((i % 2) ? 5'd4 : 5'd3) || wr_data !== ((i % 2) ? d1 : d0)) begin
        n_bad++; $display("FAIL contention_write[%0d]: got %b/%0d/%h want 1/%0d/%h", i, wr_en,
                          wr_addr, wr_data, (i % 2) ? 4 : 3, (i % 2) ? d1 : d0);
      end
    end
    idle();
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1; iss_rd = 7; tick(); idle();
    rs1 = 7; #1;
    n_cmp++;
    if (hazard !== 1'b1) begin n_bad++; $display("FAIL raw_hazard: got %b want 1", hazard); end
    r1_v = 1; r1_a = 7; r1_d = 32'h1234; #1;
    n_cmp++;
    if (hazard !== 1'b1) begin n_bad++; $display("FAIL no_bypass: got %b want 1", hazard); end
    tick(); r1_v = 0; #1;
    n_cmp++;
    if (hazard !== 1'b0) begin n_bad++; $display("FAIL hazard_release: got %b want 0", hazard); end
    iss_en = 1; iss_rd = 7; r0_v = 1; r0_a = 7; r0_d = 32'h55; tick(); idle();
    rs2 = 7; #1;
    n_cmp++;
    if (hazard !== 1'b1) begin n_bad++; $display("FAIL set_wins: got %b want 1", hazard); end
    r0_v = 1; r0_a = 7; tick(); idle();
  endtask

  task automatic test_x0();
    idle(); iss_en = 1; iss_rd = 0; tick(); idle();
    r0_v = 1; r0_a = 0; r0_d = 32'h1; #1;
    n_cmp++;
    if (r0_rdy !== 1'b1 || hazard !== 1'b0) begin
      n_bad++; $display("FAIL x0_accept: got ready=%b hazard=%b want 1/0", r0_rdy, hazard);
    end
    tick(); idle(); #1;
    n_cmp++;
    if (wr_en !== 1'b0 || hazard !== 1'b0) begin
      n_bad++; $display("FAIL x0_nowrite: got wr_en=%b hazard=%b want 0/0", wr_en, hazard);
    end
  endtask

  task automatic test_waw_reset();
    idle(); iss_en = 1; iss_rd = 9; tick();
    #1;
    n_cmp++;
    if (hazard !== 1'b1) begin n_bad++; $display("FAIL waw_hazard: got %b want 1", hazard); end
    iss_en = 0; rst = 1; r0_v = 1; r0_a = 12; tick(); rst = 0; idle(); rs1 = 9; #1;
    n_cmp++;
    if (hazard !== 1'b0 || wr_en !== 1'b0) begin
      n_bad++; $display("FAIL reset_clears: got hazard=%b wr_en=%b want 0/0", hazard, wr_en);
    end
    idle();
  endtask

  task automatic test_random();
    int w;
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 39) == 0);
      r0_v   = $urandom_range(0, 1); r1_v = $urandom_range(0, 1);
      r0_a   = $urandom_range(0, 9); r1_a = $urandom_range(0, 9);
      r0_d   = $urandom;             r1_d = $urandom;
      iss_en = $urandom_range(0, 1); iss_rd = $urandom_range(0, 9);
      rs1    = $urandom_range(0, 9); rs2 = $urandom_range(0, 9);
      #1;
      w = model_winner();
      n_cmp++;
      if (r0_rdy !== (w == 0) || r1_rdy !== (w == 1) || hazard !== model_hazard()) begin
        n_bad++; $display("FAIL rand_comb[%0d]: got rdy=%b%b haz=%b want rdy=%b%b haz=%b", c,
                          r0_rdy, r1_rdy, hazard, w == 0, w == 1, model_hazard());
      end
      tick();
      n_cmp++;
      if (wr_en !== m_wr || wr_addr !== m_addr || wr_data !== m_data) begin
        n_bad++; $display("FAIL rand_write[%0d]: got %b/%0d/%h want %b/%0d/%h", c, wr_en,
                          wr_addr, wr_data, m_wr, m_addr, m_data);
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle(); rst = 1;
    test_reset();
    test_single();
    test_back_to_back();
    test_scoreboard();
    test_x0();
    test_waw_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
